// File: rtl/textlcd_pkg.sv
// textlcd_pkg: shared types and constants for the text-LCD sequencer.
//   state_e      - sequencer states
//   INIT_LEN     - number of init bytes issued after power-up
//   INIT_ROM     - init bytes, byte k at bits [8k+7:8k]
//   is_long_cmd  - true for the clear/home commands that need the long wait
package textlcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP   = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_ENABLE    = 3'd4,
    ST_HOLD      = 3'd5,
    ST_EXEC      = 3'd6
  } state_e;

  localparam int INIT_LEN = 4;

  // Function set 8-bit/2-line, display on, entry mode increment, clear.
  localparam logic [INIT_LEN*8-1:0] INIT_ROM = {8'h01, 8'h06, 8'h0C, 8'h38};

  // Clear display (0x01) and return home (0x02/0x03) take ~1.64 ms.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/textlcd_cycle_timer.sv
// textlcd_cycle_timer: loadable down-counter shared by all timed states.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val this cycle (the state being entered lasts i_load_val+1 cycles)
//   i_load_val     : value to load
//   o_done         : high while the count is 0, i.e. in the last cycle of the state
module textlcd_cycle_timer #(
  parameter int             W         = 19,
  parameter logic [W-1:0]   RESET_VAL = {W{1'b0}}
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Down-counter: load on state entry, then count to zero and stay there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RESET_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != {W{1'b0}}) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/textlcd_sched.sv
// textlcd_sched: HD44780 8-bit write sequencer with a two-client round-robin arbiter.
//   clk, resetn                    : fabric clock, asynchronous active-low reset
//   reqN_valid/rs/data, reqN_ready : client N byte handshake (ready is combinational)
//   init_done                      : init sequence finished, sticky until reset
//   busy                           : high in every state except IDLE
//   lcd_rs/lcd_rw/lcd_en/lcd_data  : registered LCD pins (write only, lcd_rw = 0)
module textlcd_sched import textlcd_pkg::*; #(
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 8,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 1000,
  parameter int T_LONG    = 41000,
  parameter int T_POWERUP = 375000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int MAX_A = (T_POWERUP > T_LONG) ? T_POWERUP : T_LONG;
  localparam int MAX_B = (T_EXEC > T_EN) ? T_EXEC : T_EN;
  localparam int MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_T = (MAX_D > MAX_C) ? MAX_D : MAX_C;
  localparam int CW    = $clog2(MAX_T + 1);

  // Each timed state lasts (load value + 1) cycles.
  localparam logic [CW-1:0] LD_POWERUP = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] LD_SETUP   = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_EN      = CW'(T_EN - 1);
  localparam logic [CW-1:0] LD_HOLD    = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_EXEC    = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_LONG    = CW'(T_LONG - 1);

  state_e        r_state;
  logic [1:0]    r_idx;
  logic          r_init_done;
  logic          r_busy;
  logic          r_en;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_last;      // client served most recently (1 after reset so client 0 wins first)

  logic          w_grant;
  logic          w_ready0;
  logic          w_ready1;
  logic          w_xfer;
  logic          w_sel_rs;
  logic [7:0]    w_sel_data;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_done;

  // Round-robin grant: a lone requester wins, a tie goes to the client not served last.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  assign w_ready0   = (r_state == ST_IDLE) && r_init_done && req0_valid && !w_grant;
  assign w_ready1   = (r_state == ST_IDLE) && r_init_done && req1_valid &&  w_grant;
  assign w_xfer     = w_ready0 || w_ready1;
  assign w_sel_rs   = w_grant ? req1_rs   : req0_rs;
  assign w_sel_data = w_grant ? req1_data : req0_data;

  // Timer reload for the state about to be entered; POWERUP is loaded by reset.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = {CW{1'b0}};
    case (r_state)
      ST_INIT_LOAD: begin
        w_load     = 1'b1;
        w_load_val = LD_SETUP;
      end
      ST_IDLE: begin
        w_load     = w_xfer;
        w_load_val = LD_SETUP;
      end
      ST_SETUP: begin
        w_load     = w_done;
        w_load_val = LD_EN;
      end
      ST_ENABLE: begin
        w_load     = w_done;
        w_load_val = LD_HOLD;
      end
      ST_HOLD: begin
        w_load     = w_done;
        w_load_val = is_long_cmd(r_rs, r_data) ? LD_LONG : LD_EXEC;
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = {CW{1'b0}};
      end
    endcase
  end

  textlcd_cycle_timer #(
    .W         (CW),
    .RESET_VAL (LD_POWERUP)
  ) u_timer (
    .i_clk      (clk),
    .i_rst_n    (resetn),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Sequencer FSM with registered LCD pins, busy and init_done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_POWERUP;
      r_idx       <= 2'd0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_last      <= 1'b1;
    end else begin
      case (r_state)
        ST_POWERUP: begin
          if (w_done) begin
            r_state <= ST_INIT_LOAD;
            r_idx   <= 2'd0;
          end
        end
        ST_INIT_LOAD: begin
          r_rs    <= 1'b0;
          r_data  <= INIT_ROM[{r_idx, 3'b000} +: 8];
          r_state <= ST_SETUP;
        end
        ST_IDLE: begin
          if (w_xfer) begin
            r_rs    <= w_sel_rs;
            r_data  <= w_sel_data;
            r_last  <= w_grant;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_done) begin
            r_en    <= 1'b1;
            r_state <= ST_ENABLE;
          end
        end
        ST_ENABLE: begin
          if (w_done) begin
            r_en    <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_done) begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_done) begin
            if (r_init_done) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else if (r_idx == 2'(INIT_LEN - 1)) begin
              r_init_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= ST_INIT_LOAD;
            end
          end
        end
        default: begin
          r_state <= ST_POWERUP;
          r_busy  <= 1'b1;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign init_done  = r_init_done;
  assign busy       = r_busy;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = r_en;
  assign lcd_data   = r_data;

endmodule

// File: tb/tb_textlcd_sched.sv
// tb_textlcd_sched: self-checking bench for textlcd_sched with shortened timing.
// A cycle-level reference model predicts, from the timing rules, when each client
// may be served, who wins, and when/what each enable pulse carries.
module tb_textlcd_sched;

  localparam int P_PU    = 100;
  localparam int P_EXEC  = 20;
  localparam int P_LONG  = 50;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 8;
  localparam int P_HOLD  = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req0_valid, req0_rs, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_ready;
  logic [7:0] req1_data;
  logic       init_done, busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  always #20 clk = ~clk;

  textlcd_sched #(
    .T_SETUP(P_SETUP), .T_EN(P_EN), .T_HOLD(P_HOLD),
    .T_EXEC(P_EXEC), .T_LONG(P_LONG), .T_POWERUP(P_PU)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
    .init_done(init_done), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
  endtask

  // Cycles since reset release (cycle k follows the k-th rising edge).
  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // ---------------- reference model ----------------
  typedef struct { bit rs; logic [7:0] data; int start; } pulse_t;
  pulse_t     exp_q[$];
  int         pulse_start_log[$];
  logic [7:0] pulse_data_log[$];
  int         xfer_log[$];
  logic [7:0] rom_b [4];
  int         m_earliest, m_init_end, en_start;
  bit         m_armed, m_last, prev_en, e0, e1, g, m_rs;
  logic [7:0] m_d;
  pulse_t     m_p;

  function automatic int wait_for(input bit rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? P_LONG : P_EXEC;
  endfunction

  // One write occupies: 1 load/transfer cycle, setup, enable, hold, then the wait.
  function automatic int period(input bit rs, input logic [7:0] d);
    return 1 + P_SETUP + P_EN + P_HOLD + wait_for(rs, d);
  endfunction

  task automatic model_init();
    int t;
    t = P_PU;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{1'b0, rom_b[k], t + 1 + P_SETUP});
      t += period(1'b0, rom_b[k]);
    end
    m_earliest = t;
    m_init_end = t;
    m_last     = 1'b1;
    m_armed    = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk(!lcd_en && !lcd_rs && !lcd_rw && lcd_data == 8'h00 && !init_done && busy &&
            !req0_ready && !req1_ready, "reset_values",
            {lcd_en, lcd_rs, lcd_rw, init_done, busy, req0_ready, req1_ready, lcd_data},
            {7'b0000100, 8'h00});
        m_armed = 1'b0;
        prev_en = 1'b0;
        exp_q.delete();
        pulse_start_log.delete();
        pulse_data_log.delete();
      end else begin
        if (!m_armed) model_init();
        chk(busy == (cyc < m_earliest), "busy", busy, (cyc < m_earliest));
        chk(init_done == (cyc >= m_init_end), "init_done", init_done, (cyc >= m_init_end));
        e0 = 1'b0; e1 = 1'b0; g = 1'b0;
        if (cyc >= m_earliest && (req0_valid || req1_valid)) begin
          g = (req0_valid && req1_valid) ? !m_last : req1_valid;
          if (g) e1 = 1'b1; else e0 = 1'b0 | 1'b1;
        end
        chk({req0_ready, req1_ready} == {e0, e1}, "ready", {req0_ready, req1_ready}, {e0, e1});
        if (req0_valid && req0_ready) xfer_log.push_back(0);
        if (req1_valid && req1_ready) xfer_log.push_back(1);
        if (e0 || e1) begin
          m_rs = g ? req1_rs : req0_rs;
          m_d  = g ? req1_data : req0_data;
          exp_q.push_back('{m_rs, m_d, cyc + 1 + P_SETUP});
          m_earliest = cyc + period(m_rs, m_d);
          m_last     = g;
        end
        if (lcd_en && !prev_en) begin
          en_start = cyc;
          pulse_start_log.push_back(cyc);
          pulse_data_log.push_back(lcd_data);
          chk(exp_q.size() != 0, "pulse_expected", lcd_data, 0);
          if (exp_q.size() != 0) begin
            m_p = exp_q.pop_front();
            chk(cyc == m_p.start, "pulse_start", cyc, m_p.start);
            chk({lcd_rw, lcd_rs, lcd_data} == {1'b0, m_p.rs, m_p.data}, "pulse_byte",
                {lcd_rw, lcd_rs, lcd_data}, {1'b0, m_p.rs, m_p.data});
          end
        end
        if (!lcd_en && prev_en) chk(cyc - en_start == P_EN, "en_width", cyc - en_start, P_EN);
        prev_en = lcd_en;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit id, input bit v, input bit rs, input logic [7:0] d);
    if (id) begin req1_valid = v; req1_rs = rs; req1_data = d; end
    else    begin req0_valid = v; req0_rs = rs; req0_data = d; end
  endtask

  task automatic wait_cyc(input int k);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (cyc >= k) break;
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic send_one(input bit id, input bit rs, input logic [7:0] d,
                          output int bcnt, output bit got);
    got = 1'b0; bcnt = 0;
    @(posedge clk); #1; drive(id, 1'b1, rs, d);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1; drive(id, 1'b0, rs, d);
    if (got) begin
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (!busy) break;
        bcnt++;
      end
    end
  endtask

  task automatic rand_client(input bit id, input int nbytes);
    int         gap, hold;
    bit         got, rs;
    logic [7:0] d;
    for (int k = 0; k < nbytes; k++) begin
      gap = $urandom_range(0, 40);
      repeat (gap) @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) begin rs = 1'b0; d = 8'($urandom_range(1, 3)); end
      else begin rs = 1'($urandom_range(0, 1)); d = 8'($urandom_range(0, 255)); end
      drive(id, 1'b1, rs, d);
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 400;
      got  = 1'b0;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (id ? req1_ready : req0_ready) begin got = 1'b1; break; end
      end
      @(posedge clk); #1; drive(id, 1'b0, rs, d);
      chk(got || hold != 400, "rand_timeout", got, 1);
    end
  endtask

  typedef struct { bit client; bit rs; logic [7:0] data; int exp_busy; } vec_t;
  vec_t tbl [7];

  initial begin : main
    int  bcnt, rc, n0, n1, base, gi;
    bit  got, seen;

    rom_b[0] = 8'h38; rom_b[1] = 8'h0C; rom_b[2] = 8'h06; rom_b[3] = 8'h01;
    // busy after transfer = setup + enable + hold + wait = 12 + wait
    tbl[0] = '{1'b0, 1'b1, 8'h41, 32};
    tbl[1] = '{1'b1, 1'b0, 8'h01, 62};
    tbl[2] = '{1'b1, 1'b0, 8'h80, 32};
    tbl[3] = '{1'b0, 1'b0, 8'h02, 62};
    tbl[4] = '{1'b0, 1'b0, 8'h03, 62};
    tbl[5] = '{1'b0, 1'b1, 8'h01, 32};
    tbl[6] = '{1'b1, 1'b0, 8'h04, 32};

    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;

    // Power-up, init sequence, and a request raised during init.
    wait_cyc(50);
    @(posedge clk); #1; drive(1'b0, 1'b1, 1'b1, 8'h55);
    wait_cyc(100);
    chk(lcd_data == 8'h00 && cyc == 100, "data_before_init", lcd_data, 8'h00);
    @(negedge clk);
    chk(lcd_data == 8'h38 && !lcd_rs, "first_init_byte", {lcd_rs, lcd_data}, 9'h038);
    got = 1'b0; rc = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (req0_ready) begin got = 1'b1; rc = cyc; break; end
    end
    @(posedge clk); #1; drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk(got, "init_ready_seen", got, 1);
    chk(rc == 262, "ready_after_init", rc, 262);
    wait_idle();
    chk(pulse_start_log.size() == 5, "init_pulse_count", pulse_start_log.size(), 5);
    chk(pulse_start_log[0] == 103, "first_pulse_cycle", pulse_start_log[0], 103);
    for (int k = 0; k < 4; k++) chk(pulse_data_log[k] == rom_b[k], "init_byte", pulse_data_log[k], rom_b[k]);
    chk(pulse_data_log[4] == 8'h55, "queued_byte", pulse_data_log[4], 8'h55);

    // Table of single transfers: ready seen, and busy length after the transfer.
    for (int i = 0; i < 7; i++) begin
      send_one(tbl[i].client, tbl[i].rs, tbl[i].data, bcnt, got);
      chk(got, "vec_ready", got, 1);
      chk(bcnt == tbl[i].exp_busy, "vec_busy", bcnt, tbl[i].exp_busy);
    end

    // Both clients held valid for 4 bytes each: strict alternation starting with client 0.
    base = xfer_log.size();
    n0 = 0; n1 = 0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 8'h41);
    drive(1'b1, 1'b1, 1'b1, 8'h42);
    for (int c = 0; c < 2000 && (n0 < 4 || n1 < 4); c++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) n0++;
      if (req1_valid && req1_ready) n1++;
      @(posedge clk); #1;
      if (n0 >= 4) req0_valid = 1'b0;
      if (n1 >= 4) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk(n0 == 4 && n1 == 4, "both_counts", {n0[7:0], n1[7:0]}, 16'h0404);
    for (int k = 0; k < 8; k++) begin
      gi = xfer_log[base + k];
      chk(gi == (k % 2), "rr_order", gi, k % 2);
    end
    wait_idle();

    // Randomised traffic from both clients, checked by the model.
    fork
      rand_client(1'b0, 10);
      rand_client(1'b1, 10);
    join
    wait_idle();

    // Reset pulsed while lcd_en is high.
    @(posedge clk); #1; drive(1'b0, 1'b1, 1'b1, 8'h5A);
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (lcd_en) begin seen = 1'b1; break; end
      if (req0_ready) begin @(posedge clk); #1; req0_valid = 1'b0; end
    end
    req0_valid = 1'b0;
    chk(seen, "en_before_reset", seen, 1);
    #5 resetn = 1'b0;
    #1;
    chk(!lcd_en && !init_done && busy, "async_reset", {lcd_en, init_done, busy}, 3'b001);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    wait_cyc(100);
    chk(lcd_data == 8'h00 && cyc == 100, "data_before_reinit", lcd_data, 8'h00);
    @(negedge clk);
    chk(lcd_data == 8'h38, "first_reinit_byte", lcd_data, 8'h38);
    got = 1'b0; rc = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (init_done) begin got = 1'b1; rc = cyc; break; end
    end
    chk(got && rc == 262, "reinit_done_cycle", rc, 262);
    chk(pulse_start_log.size() == 4, "reinit_pulse_count", pulse_start_log.size(), 4);
    chk(pulse_start_log[0] == 103, "reinit_first_pulse", pulse_start_log[0], 103);

    repeat (5) @(negedge clk);
    chk(exp_q.size() == 0, "pulses_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
